rej_uniform_sampler: RTL
========================

REJ_UNIFORM_SAMPLER -- requirements
Module: rej_uniform_sampler

Interface
REQ-001 SHALL have parameter BUFLEN, default 840, meaning input buffer length in bytes (5 SHAKE128 blocks of 168 bytes).
REQ-002 SHALL have parameter N, default 256, meaning target coefficient count.
REQ-003 SHALL have parameter Q, default 8380417, meaning rejection modulus.
REQ-004 SHALL have port clock, input, 1, meaning sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning level request; latched on rising of operation, held until done.
REQ-007 SHALL have port buf_in, input, BUFLEN*8, meaning squeezed byte stream; byte i = buf_in[8i+7:8i].
REQ-008 SHALL have port coeff_out, output, 23, meaning accepted coefficient.
REQ-009 SHALL have port coeff_valid, output, 1, meaning coeff_out/coeff_idx valid this cycle.
REQ-010 SHALL have port coeff_idx, output, 8, meaning destination index of coeff_out.
REQ-011 SHALL have port ctr, output, 9, meaning accepted count so far (0..N).
REQ-012 SHALL have port done, output, 1, meaning operation finished; ctr final.

Function
REQ-013 SHALL implement states IDLE, LOAD, SCAN, DONE.
REQ-014 IDLE -> LOAD when start=1; LOAD latches buf_in into internal register, clears pos to 0, and clears ctr to 0.
REQ-015 LOAD -> SCAN unconditionally after one cycle; buf_in is ignored after LOAD.
REQ-016 In SCAN, each cycle SHALL form t = b[pos] | b[pos+1]<<8 | (b[pos+2]&0x7F)<<16 and advance pos by 3.
REQ-017 If t < Q, SHALL assert coeff_valid for that cycle with coeff_out=t and coeff_idx=ctr[7:0], and increment ctr; otherwise coeff_valid=0.
REQ-018 SCAN -> DONE when ctr reaches N (including the cycle it reaches N) or when pos+3 > BUFLEN after the advance; no byte beyond BUFLEN-1 SHALL be read.
REQ-019 Comparison SHALL be unsigned 23-bit; ctr SHALL saturate at N and never wrap.
REQ-020 DONE SHALL hold done=1 while start=1; DONE -> IDLE when start=0, with done falling in the same cycle start is seen low.
REQ-021 Throughput: one 3-byte group per SCAN cycle; at most one coefficient per cycle.
REQ-022 start deasserted mid-SCAN SHALL be ignored; the operation runs to DONE.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, pos=0, ctr=0, coeff_out=0, coeff_idx=0, coeff_valid=0, done=0, at any state including mid-SCAN.
REQ-024 Buffer register contents SHALL be don't-care after reset.

Configuration
REQ-025 Macro REJ_UNIFORM_RESUME_EN SHALL, when defined, add input resume (1 bit), sampled in IDLE with start: resume=1 keeps ctr, resume=0 clears ctr in LOAD.
REQ-026 With REJ_UNIFORM_RESUME_EN defined, resume=1 with ctr=N SHALL pass LOAD -> DONE without emitting coefficients.
REQ-027 Without REJ_UNIFORM_RESUME_EN, port resume SHALL NOT exist and every start SHALL clear ctr.

Structure
REQ-028 Q, N, the 23-bit coefficient width, and state encodings SHALL be placed in shared package dilithium_pkg.
REQ-029 The 3-byte extract and compare SHALL be sub-module rej_uniform_extract (combinational: buffer, pos -> t, accept); the FSM stays in the top module.

Verification
REQ-030 All-zero buf_in, start -> 256 coeff_valid pulses of 0, coeff_idx 0..255, done with ctr=256 after 256 SCAN cycles.
REQ-031 All-0xFF buf_in -> no coeff_valid, done after 280 SCAN cycles, ctr=0.
REQ-032 First bytes 0x01,0xE0,0x7F (t=Q) -> rejected; bytes 0x00,0xE0,0x7F (t=Q-1=8380416) -> accepted at idx 0; bytes 0x00,0x00,0x80 -> t=0, accepted (bit 23 masked).
REQ-033 Reset asserted in the 10th SCAN cycle -> all outputs 0 immediately, state IDLE; new start restarts from ctr=0.
REQ-034 With REJ_UNIFORM_RESUME_EN defined, a first run ending at ctr=200, then resume=1 start with all-zero buffer -> 56 coefficients at idx 200..255, done with ctr=256.
REQ-035 start held high after done -> done stays 1, no extra pulses; start low -> done 0, state IDLE.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants: modulus, coefficient count and width, and sampler state encoding.
package dilithium_pkg;

  localparam int unsigned DIL_Q   = 32'd8380417;
  localparam int          DIL_N   = 256;
  localparam int          COEFF_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } rej_state_t;

endpackage

// File: rtl/rej_uniform_extract.sv
// Combinational 3-byte extract at a byte position plus the unsigned t < Q acceptance test.
module rej_uniform_extract
  import dilithium_pkg::*;
#(
  parameter int          BUFLEN = 840,
  parameter int unsigned Q      = DIL_Q,
  parameter int          PW     = 10
) (
  input  logic [BUFLEN*8-1:0] buf_i,
  input  logic [PW-1:0]       pos_i,
  output logic [COEFF_W-1:0]  t_o,
  output logic                accept_o
);

  logic [7:0]    bytes_w [BUFLEN];
  logic [PW-1:0] pos1_w;
  logic [PW-1:0] pos2_w;

  for (genvar gi = 0; gi < BUFLEN; gi++) begin : g_bytes
    assign bytes_w[gi] = buf_i[8*gi +: 8];
  end

  assign pos1_w = pos_i + PW'(1);
  assign pos2_w = pos_i + PW'(2);

  // Bit 7 of the third byte is discarded so t is always 23 bits.
  assign t_o      = {bytes_w[pos2_w][6:0], bytes_w[pos1_w], bytes_w[pos_i]};
  assign accept_o = (32'(t_o) < Q);

endmodule

// File: rtl/rej_uniform_sampler.sv
// Rejection sampler FSM: latches the squeezed buffer, scans one 3-byte group per cycle, registers accepted coefficients.
// Optional macro REJ_UNIFORM_RESUME_EN adds a resume input that keeps the accepted count across starts.
module rej_uniform_sampler
  import dilithium_pkg::*;
#(
  parameter int          BUFLEN = 840,
  parameter int          N      = DIL_N,
  parameter int unsigned Q      = DIL_Q
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
`ifdef REJ_UNIFORM_RESUME_EN
  input  logic                resume,
`endif
  input  logic [BUFLEN*8-1:0] buf_in,
  output logic [COEFF_W-1:0]  coeff_out,
  output logic                coeff_valid,
  output logic [7:0]          coeff_idx,
  output logic [8:0]          ctr,
  output logic                done
);

  localparam int            PW       = $clog2(BUFLEN + 4);
  localparam logic [8:0]    N_CTR    = 9'(N);
  localparam logic [PW-1:0] POS_LAST = PW'(BUFLEN - 3);

  rej_state_t           state_q, state_d;
  logic [BUFLEN*8-1:0]  buf_q, buf_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [8:0]           ctr_q, ctr_d;
  logic [COEFF_W-1:0]   coeff_out_q, coeff_out_d;
  logic [7:0]           coeff_idx_q, coeff_idx_d;
  logic                 coeff_valid_q, coeff_valid_d;
  logic                 done_q, done_d;
  logic                 resume_q;
  logic [COEFF_W-1:0]   t_w;
  logic                 accept_w;

`ifdef REJ_UNIFORM_RESUME_EN
  logic resume_d;
`else
  assign resume_q = 1'b0;
`endif

  rej_uniform_extract #(.BUFLEN(BUFLEN), .Q(Q), .PW(PW)) u_extract (
    .buf_i   (buf_q),
    .pos_i   (pos_q),
    .t_o     (t_w),
    .accept_o(accept_w)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    pos_d         = pos_q;
    ctr_d         = ctr_q;
    coeff_out_d   = coeff_out_q;
    coeff_idx_d   = coeff_idx_q;
    coeff_valid_d = 1'b0;
    done_d        = done_q;
`ifdef REJ_UNIFORM_RESUME_EN
    resume_d      = resume_q;
`endif
    case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
`ifdef REJ_UNIFORM_RESUME_EN
          resume_d = resume;
`endif
        end
      end
      ST_LOAD: begin
        buf_d = buf_in;
        pos_d = '0;
        if (!resume_q) ctr_d = '0;
        // A resumed run that is already full has nothing to scan.
        if (resume_q && ctr_q == N_CTR) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        pos_d = pos_q + PW'(3);
        if (accept_w && ctr_q != N_CTR) begin
          coeff_valid_d = 1'b1;
          coeff_out_d   = t_w;
          coeff_idx_d   = ctr_q[7:0];
          ctr_d         = ctr_q + 9'd1;
        end
        if (ctr_d == N_CTR || pos_d > POS_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pos_q         <= '0;
      ctr_q         <= '0;
      coeff_out_q   <= '0;
      coeff_idx_q   <= '0;
      coeff_valid_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef REJ_UNIFORM_RESUME_EN
      resume_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      ctr_q         <= ctr_d;
      coeff_out_q   <= coeff_out_d;
      coeff_idx_q   <= coeff_idx_d;
      coeff_valid_q <= coeff_valid_d;
      done_q        <= done_d;
`ifdef REJ_UNIFORM_RESUME_EN
      resume_q      <= resume_d;
`endif
    end
  end

  // The buffer holds no state that matters across reset, so it has none.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign coeff_out   = coeff_out_q;
  assign coeff_valid = coeff_valid_q;
  assign coeff_idx   = coeff_idx_q;
  assign ctr         = ctr_q;
  assign done        = done_q;

endmodule
